// File: rtl/tpu_tile_scheduler.sv
// Walks the (M/4)x(N/4) output tiles of a matrix job in row-major order,
// launching the 4x4 tile engine once per tile and reporting job completion.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for a start with legal dimensions
// LAUNCH    | first cycle of a tile launch, core_in_valid raised
// WAIT_ACK  | core_in_valid held until the engine reports busy
// WAIT_DONE | engine working on the current tile
// NEXT      | advance tile indices, decide between next tile and finish
// FIN       | one-cycle done pulse
module tpu_tile_scheduler #(
   parameter int ADDR_BITS = 16,
   parameter int DIM_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [DIM_BITS-1:0]  K,
   input  logic [DIM_BITS-1:0]  M,
   input  logic [DIM_BITS-1:0]  N,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic                 core_in_valid,
   output logic [DIM_BITS-1:0]  core_K,
   input  logic                 core_busy,
   output logic [ADDR_BITS-1:0] a_base,
   output logic [ADDR_BITS-1:0] b_base,
   output logic [ADDR_BITS-1:0] c_base,
   output logic [DIM_BITS-1:0]  tile_m,
   output logic [DIM_BITS-1:0]  tile_n
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] LAUNCH    = 3'd1;
   localparam logic [2:0] WAIT_ACK  = 3'd2;
   localparam logic [2:0] WAIT_DONE = 3'd3;
   localparam logic [2:0] NEXT      = 3'd4;
   localparam logic [2:0] FIN       = 3'd5;

   logic [2:0]          state_q, state_d;
   logic [DIM_BITS-1:0] k_q, k_d;
   logic [DIM_BITS-1:0] mt_q, mt_d;
   logic [DIM_BITS-1:0] nt_q, nt_d;
   logic [DIM_BITS-1:0] tile_m_q, tile_m_d;
   logic [DIM_BITS-1:0] tile_n_q, tile_n_d;
   logic                err_q, err_d;

   logic dims_legal;
   logic last_col;
   logic last_tile;

   assign dims_legal = (K != '0) && (K[1:0] == 2'b00) &&
                       (M != '0) && (M[1:0] == 2'b00) &&
                       (N != '0) && (N[1:0] == 2'b00);

   assign last_col  = (tile_n_q == nt_q - DIM_BITS'(1));
   assign last_tile = last_col && (tile_m_q == mt_q - DIM_BITS'(1));

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      mt_d     = mt_q;
      nt_d     = nt_q;
      tile_m_d = tile_m_q;
      tile_n_d = tile_n_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (dims_legal) begin
                  k_d      = K;
                  mt_d     = {2'b00, M[DIM_BITS-1:2]};
                  nt_d     = {2'b00, N[DIM_BITS-1:2]};
                  tile_m_d = '0;
                  tile_n_d = '0;
                  err_d    = 1'b0;
                  state_d  = LAUNCH;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LAUNCH:    state_d = WAIT_ACK;
         WAIT_ACK:  if (core_busy)  state_d = WAIT_DONE;
         WAIT_DONE: if (!core_busy) state_d = NEXT;
         NEXT: begin
            // Indices stay on the final tile so FIN still shows the last addresses
            if (last_tile) begin
               state_d = FIN;
            end else begin
               state_d = LAUNCH;
               if (last_col) begin
                  tile_n_d = '0;
                  tile_m_d = tile_m_q + DIM_BITS'(1);
               end else begin
                  tile_n_d = tile_n_q + DIM_BITS'(1);
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort && (state_q != IDLE)) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         k_q      <= '0;
         mt_q     <= '0;
         nt_q     <= '0;
         tile_m_q <= '0;
         tile_n_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         mt_q     <= mt_d;
         nt_q     <= nt_d;
         tile_m_q <= tile_m_d;
         tile_n_q <= tile_n_d;
         err_q    <= err_d;
      end
   end

   // Outputs decode the registered state, so reset removes them asynchronously
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == FIN);
   assign core_in_valid = (state_q == LAUNCH) || (state_q == WAIT_ACK);
   assign err           = err_q;
   assign core_K        = k_q;
   assign tile_m        = tile_m_q;
   assign tile_n        = tile_n_q;

   // Multiplying operands already cut to ADDR_BITS gives the same low bits as
   // the full-width product, so wrap-around matches a truncated wide multiply.
   assign a_base = ADDR_BITS'(tile_m_q) * ADDR_BITS'(k_q);
   assign b_base = ADDR_BITS'(tile_n_q) * ADDR_BITS'(k_q);
   assign c_base = (ADDR_BITS'(tile_m_q) * ADDR_BITS'(nt_q) + ADDR_BITS'(tile_n_q))
                   * ADDR_BITS'(4);

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Scoreboard bench for tpu_tile_scheduler: expected tile launches and done
// pulses are queued by the stimulus and consumed by an independent monitor.
module tb_tpu_tile_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        core_busy = 1'b0;
   logic [7:0]  K = '0, M = '0, N = '0;
   logic        busy, done, err, core_in_valid;
   logic [7:0]  core_K, tile_m, tile_n;
   logic [15:0] a_base, b_base, c_base;

   typedef struct packed {
      logic [7:0]  tm;
      logic [7:0]  tn;
      logic [7:0]  k;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
   } launch_t;

   launch_t exp_q[$];
   launch_t cur;
   int      exp_done = 0;
   int      n_cmp = 0;
   int      n_fail = 0;
   int      ack_dly = 1;
   int      busy_len = 10;

   tpu_tile_scheduler #(.ADDR_BITS(16), .DIM_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .K(K), .M(M), .N(N),
      .abort(abort), .busy(busy), .done(done), .err(err),
      .core_in_valid(core_in_valid), .core_K(core_K), .core_busy(core_busy),
      .a_base(a_base), .b_base(b_base), .c_base(c_base),
      .tile_m(tile_m), .tile_n(tile_n)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic push1(input int tm, input int tn, input int k, input int a, input int b, input int c);
      launch_t l;
      l.tm = 8'(tm); l.tn = 8'(tn); l.k = 8'(k);
      l.a = 16'(a); l.b = 16'(b); l.c = 16'(c);
      exp_q.push_back(l);
   endtask

   task automatic push_job(input int k, input int m, input int n);
      for (int tm = 0; tm < m / 4; tm++)
         for (int tn = 0; tn < n / 4; tn++)
            push1(tm, tn, k, tm * k, tn * k, (tm * (n / 4) + tn) * 4);
   endtask

   task automatic issue_start(input int k, input int m, input int n);
      @(negedge clk);
      K = 8'(k); M = 8'(m); N = 8'(n); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("accept_busy", busy, 1);
      check("accept_valid", core_in_valid, 1);
      check("accept_err_clear", err, 0);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy) return;
      end
      check("idle_timeout", busy, 0);
   endtask

   task automatic wait_engine_idle();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!core_busy) return;
      end
      check("engine_timeout", core_busy, 0);
   endtask

   task automatic run_job(input int k, input int m, input int n);
      exp_done++;
      issue_start(k, m, n);
      wait_idle();
      check("pending_launches", exp_q.size(), 0);
      check("pending_done", exp_done, 0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_valid"}, core_in_valid, 0);
      check({tag, "_core_K"}, core_K, 0);
      check({tag, "_tile_m"}, tile_m, 0);
      check({tag, "_tile_n"}, tile_n, 0);
      check({tag, "_a"}, a_base, 0);
      check({tag, "_b"}, b_base, 0);
      check({tag, "_c"}, c_base, 0);
   endtask

   task automatic try_illegal(input int k, input int m, input int n);
      @(negedge clk);
      K = 8'(k); M = 8'(m); N = 8'(n); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("illegal_err", err, 1);
      for (int i = 0; i < 3; i++) begin
         check("illegal_busy", busy, 0);
         check("illegal_valid", core_in_valid, 0);
         @(negedge clk);
      end
      check("illegal_err_sticky", err, 1);
   endtask

   // Engine model: acks ack_dly+1 cycles after seeing valid, busy for busy_len+1
   initial begin
      int st;
      int cnt;
      st = 0;
      cnt = 0;
      forever begin
         @(negedge clk);
         case (st)
            0: if (core_in_valid) begin cnt = ack_dly; st = 1; end
            1: if (cnt == 0) begin core_busy = 1'b1; cnt = busy_len; st = 2; end
               else cnt--;
            default: if (cnt == 0) begin core_busy = 1'b0; st = 0; end
                     else cnt--;
         endcase
      end
   end

   // Monitor: consumes expected launches and done pulses
   initial begin
      logic pv;
      logic pd;
      pv = 1'b0;
      pd = 1'b0;
      forever begin
         @(negedge clk);
         if (pd) check("busy_after_done", busy, 0);
         if (done) begin
            if (exp_done == 0) check("unexpected_done", done, 0);
            else begin
               exp_done--;
               check("busy_at_done", busy, 1);
            end
         end
         pd = done;
         if (core_in_valid && !pv) begin
            if (exp_q.size() == 0) check("unexpected_launch", core_in_valid, 0);
            else begin
               cur = exp_q.pop_front();
               check("tile_m", tile_m, cur.tm);
               check("tile_n", tile_n, cur.tn);
               check("core_K", core_K, cur.k);
               check("a_base", a_base, cur.a);
               check("b_base", b_base, cur.b);
               check("c_base", c_base, cur.c);
            end
         end else if (core_in_valid) begin
            check("hold_a_base", a_base, cur.a);
            check("hold_b_base", b_base, cur.b);
            check("hold_c_base", c_base, cur.c);
            check("hold_tile_n", tile_n, cur.tn);
         end
         pv = core_in_valid;
      end
   end

   initial begin
      bit found;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;

      // Single-tile job
      ack_dly = 1; busy_len = 10;
      push_job(4, 4, 4);
      run_job(4, 4, 4);

      // 2x3 tiles, hand-computed addresses
      ack_dly = 0; busy_len = 3;
      push1(0, 0, 8, 0, 0, 0);
      push1(0, 1, 8, 0, 8, 4);
      push1(0, 2, 8, 0, 16, 8);
      push1(1, 0, 8, 8, 0, 12);
      push1(1, 1, 8, 8, 8, 16);
      push1(1, 2, 8, 8, 16, 20);
      run_job(8, 8, 12);

      // Illegal dimensions, each followed by a legal job
      try_illegal(4, 6, 4);
      push_job(4, 4, 8);
      run_job(4, 4, 8);
      try_illegal(0, 4, 4);
      push_job(4, 4, 4);
      run_job(4, 4, 4);
      try_illegal(4, 4, 3);
      push_job(12, 8, 4);
      run_job(12, 8, 4);

      // Slow ack plus a stray start mid-job
      ack_dly = 6; busy_len = 2;
      push_job(4, 4, 8);
      exp_done++;
      issue_start(4, 4, 8);
      repeat (4) @(negedge clk);
      K = 8'd12; M = 8'd12; N = 8'd12; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      check("stray_start_launches", exp_q.size(), 0);
      check("stray_start_done", exp_done, 0);

      // Abort in WAIT_DONE of tile (0,1) of a 2x2 job
      ack_dly = 0; busy_len = 10;
      push1(0, 0, 4, 0, 0, 0);
      push1(0, 1, 4, 0, 4, 4);
      issue_start(4, 8, 8);
      found = 1'b0;
      for (int i = 0; i < 500 && !found; i++) begin
         @(negedge clk);
         if (busy && !core_in_valid && core_busy && tile_n == 8'd1) found = 1'b1;
      end
      check("abort_reached_wait_done", found, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_valid", core_in_valid, 0);
      check("abort_err", err, 0);
      check("abort_launches", exp_q.size(), 0);
      wait_engine_idle();
      push_job(4, 4, 4);
      run_job(4, 4, 4);

      // Reset during WAIT_ACK
      ack_dly = 5; busy_len = 3;
      push_job(4, 4, 4);
      issue_start(4, 4, 4);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", core_in_valid, 0);
      check("async_rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check_reset_vals("post_reset");
      check("post_reset_launches", exp_q.size(), 0);
      push_job(4, 8, 4);
      run_job(4, 8, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
